id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage core. Latches decoded fields and operands from ID and presents them to EX and to the data-hazard forwarding unit (rs, rt, reg3, regWrite).
- Contains load-use detection. It stalls PC and IF/ID and inserts one bubble, because forwarding cannot cover a load followed immediately by a dependent instruction.
- Honours a downstream freeze (hold_i) and a branch flush (flush_i).

Parameters:
- DATA_W, 32, operand/immediate width
- ALUOP_W, 4, ALU opcode width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid_i  in  1  ID holds a real instruction
- id_rs_i  in  `REG_LENGTH_IN_INST  source reg A
- id_rt_i  in  `REG_LENGTH_IN_INST  source reg B
- id_rtUsed_i  in  1  instruction reads rt (R-type/store/branch)
- id_reg3_i  in  `REG_LENGTH_IN_INST  destination reg
- id_regWrite_i  in  1
- id_memRead_i  in  1
- id_memWrite_i  in  1
- id_aluSrc_i  in  1  1 = immediate operand B
- id_aluOp_i  in  ALUOP_W
- id_rdata1_i  in  DATA_W
- id_rdata2_i  in  DATA_W
- id_imm_i  in  DATA_W  sign-extended immediate
- flush_i  in  1  branch taken in EX; kill the ID instruction
- hold_i  in  1  downstream (MEM wait) freeze
- stall_o  out  1  hold PC and IF/ID this cycle
- ex_valid_o, ex_rs_o, ex_rt_o, ex_reg3_o, ex_regWrite_o, ex_memRead_o, ex_memWrite_o, ex_aluSrc_o, ex_aluOp_o, ex_rdata1_o, ex_rdata2_o, ex_imm_o  out  (widths as inputs)  registered EX-side copies
- stall_cnt_o  out  32  load-use stall count (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset: all ex_* outputs are 0 (a bubble). FSM is in RUN. pend_flush=0. stall_cnt_o=0.
- Bubble definition: valid, regWrite, memRead, memWrite, aluSrc, aluOp = 0; rs, rt, reg3 = 0; data fields = 0.
- lu_hit (combinational):
  - ex_valid_o & ex_memRead_o & (ex_reg3_o != 0)
  - & id_valid_i
  - & (ex_reg3_o == id_rs_i | (id_rtUsed_i & ex_reg3_o == id_rt_i)).
- stall_o = hold_i | (lu_hit & ~flush_i & ~pend_flush). Combinational, same cycle.
- Update priority each rising edge:
  1. hold_i=1: all ex_* hold. If flush_i=1, set pend_flush=1.
  2. flush_i | pend_flush: load bubble; clear pend_flush.
  3. lu_hit: load bubble. The ID instruction is retained upstream by stall_o.
  4. Otherwise: load the ID fields. ex_valid_o = id_valid_i.
- FSM:
  - RUN: lu_hit & ~hold_i & ~flush_i & ~pend_flush goes to BUBBLE.
  - BUBBLE: the load is now in MEM, so lu_hit is necessarily 0. Next non-hold edge loads ID, then RUN.
  - hold_i in either state: stay.
  - flush in BUBBLE: load bubble, go to RUN.
  - Stall length is exactly one cycle per load-use, excluding hold cycles.
- Load-use with rt where id_rtUsed_i=0 (I-type rt is a destination): no stall.
- reg3 = 0 never stalls.
- Back-to-back loads with a dependent third instruction are resolved by forwarding; no stall.
- Reset mid-stall: immediate return to RUN with a bubble; stall_o drops asynchronously.
- Latency: 1 cycle ID to EX.

Optional Feature:
- Macro LOAD_USE_STAT_EN.
- Defined: stall_cnt_o increments by 1 on every edge where FSM is RUN and transitions to BUBBLE. Wraps at 2^32-1 to 0. Reset value 0.
- Undefined: stall_cnt_o is tied 0 and no counter flops exist.

Decomposition:
- defines.v (shared):
  - `REG_LENGTH_IN_INST
  - ALUOP_W default
  - FSM encodings ST_RUN=1'b0, ST_BUBBLE=1'b1
  - bubble aluOp constant ALU_NOP
- One natural sub-module: load_use_detect, the combinational lu_hit comparator. It is reusable by a future 2-issue variant.

Test Plan:
- Reset then pass-through: rst_n low for 2 cycles; all ex_* = 0. Release; ID add $3=$1+$2 (rs=1, rt=2, reg3=3, regWrite=1). Next edge: ex_reg3_o=3, ex_valid_o=1, stall_o=0.
- Load-use on rs:
  - EX holds lw $5 (memRead=1, reg3=5); ID holds add with rs=5.
  - stall_o=1 that cycle. Next edge: EX is a bubble (ex_regWrite_o=0), FSM=BUBBLE, stall_o=0.
  - Following edge: the add appears in EX with rs=5.
- Load-use on rt with rtUsed=0:
  - lw $5 in EX; ID addi with rt=5, id_rtUsed_i=0. Then stall_o=0 and no bubble.
  - Repeat with rt=5, rtUsed=1: stall_o=1.
- Flush beats load-use: lw $5 in EX; ID uses $5; flush_i=1. Then stall_o=0, next edge is a bubble, FSM stays RUN, stall_cnt_o unchanged.
- Hold with flush:
  - hold_i=1 for 3 cycles; ex_* are frozen at the prior values and stall_o=1.
  - flush_i pulses in cycle 2. On the first edge after hold_i falls, a bubble is loaded.
- Counter (LOAD_USE_STAT_EN): 4 separate load-use events, with one event interrupted by a 2-cycle hold. Result: stall_cnt_o=4.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: register-index width,
// default ALU opcode width, FSM encoding and the bubble ALU opcode.
package id_ex_stage_reg_pkg;

  // Width of a register index field in an instruction (32 GPRs).
  localparam int REG_LENGTH_IN_INST = 5;

  // Default ALU opcode width.
  localparam int ALUOP_W_DEF = 4;

  // Load-use FSM: RUN normally, BUBBLE for the one cycle after a load-use bubble.
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_e;

  // ALU opcode carried by a bubble.
  localparam logic [ALUOP_W_DEF-1:0] ALU_NOP = '0;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Kept separate so a dual-issue variant
// can instantiate one per slot.
module id_ex_stage_reg_load_use_detect
  import id_ex_stage_reg_pkg::*;
(
  input  logic                          ex_valid_i,
  input  logic                          ex_mem_read_i,
  input  logic [REG_LENGTH_IN_INST-1:0] ex_reg3_i,
  input  logic                          id_valid_i,
  input  logic [REG_LENGTH_IN_INST-1:0] id_rs_i,
  input  logic [REG_LENGTH_IN_INST-1:0] id_rt_i,
  input  logic                          id_rt_used_i,
  output logic                          lu_hit_o
);

  logic ex_is_load;
  logic src_match;

  // A load into $0 writes nothing, so it can never cause a hazard.
  assign ex_is_load = ex_valid_i & ex_mem_read_i & (ex_reg3_i != '0);

  // rt only counts when the instruction actually reads it (not I-type dest).
  assign src_match  = (ex_reg3_i == id_rs_i) | (id_rt_used_i & (ex_reg3_i == id_rt_i));

  assign lu_hit_o   = ex_is_load & id_valid_i & src_match;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall/bubble insertion, downstream
// freeze (hold_i) and branch flush (flush_i). A flush that arrives during a
// freeze is remembered and applied on the first non-hold edge.
// Optional: define LOAD_USE_STAT_EN to build the 32-bit load-use stall counter
// on stall_cnt_o; otherwise stall_cnt_o is tied to zero.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = ALUOP_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid_i,
  input  logic [REG_LENGTH_IN_INST-1:0] id_rs_i,
  input  logic [REG_LENGTH_IN_INST-1:0] id_rt_i,
  input  logic                          id_rtUsed_i,
  input  logic [REG_LENGTH_IN_INST-1:0] id_reg3_i,
  input  logic                          id_regWrite_i,
  input  logic                          id_memRead_i,
  input  logic                          id_memWrite_i,
  input  logic                          id_aluSrc_i,
  input  logic [ALUOP_W-1:0]            id_aluOp_i,
  input  logic [DATA_W-1:0]             id_rdata1_i,
  input  logic [DATA_W-1:0]             id_rdata2_i,
  input  logic [DATA_W-1:0]             id_imm_i,
  input  logic                          flush_i,
  input  logic                          hold_i,
  output logic                          stall_o,
  output logic                          ex_valid_o,
  output logic [REG_LENGTH_IN_INST-1:0] ex_rs_o,
  output logic [REG_LENGTH_IN_INST-1:0] ex_rt_o,
  output logic [REG_LENGTH_IN_INST-1:0] ex_reg3_o,
  output logic                          ex_regWrite_o,
  output logic                          ex_memRead_o,
  output logic                          ex_memWrite_o,
  output logic                          ex_aluSrc_o,
  output logic [ALUOP_W-1:0]            ex_aluOp_o,
  output logic [DATA_W-1:0]             ex_rdata1_o,
  output logic [DATA_W-1:0]             ex_rdata2_o,
  output logic [DATA_W-1:0]             ex_imm_o,
  output logic [31:0]                   stall_cnt_o
);

  state_e                          state_q;
  logic                            pend_flush_q;
  logic                            ex_valid_q, ex_regWrite_q, ex_memRead_q;
  logic                            ex_memWrite_q, ex_aluSrc_q;
  logic [REG_LENGTH_IN_INST-1:0]   ex_rs_q, ex_rt_q, ex_reg3_q;
  logic [ALUOP_W-1:0]              ex_aluOp_q;
  logic [DATA_W-1:0]               ex_rdata1_q, ex_rdata2_q, ex_imm_q;
  logic                            lu_hit;

  id_ex_stage_reg_load_use_detect u_lu_detect (
    .ex_valid_i    (ex_valid_q),
    .ex_mem_read_i (ex_memRead_q),
    .ex_reg3_i     (ex_reg3_q),
    .id_valid_i    (id_valid_i),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .id_rt_used_i  (id_rtUsed_i),
    .lu_hit_o      (lu_hit)
  );

  // A pending or current flush kills the ID instruction, so it cannot stall.
  assign stall_o = hold_i | (lu_hit & ~flush_i & ~pend_flush_q);

  // Pipeline register and load-use FSM, updated in priority order:
  // hold, flush, load-use bubble, normal load.
  // NOTE: every register here is assigned with <= so all of them sample the
  // pre-edge values; a blocking '=' would let later lines see updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      pend_flush_q  <= 1'b0;
      ex_valid_q    <= 1'b0;
      ex_rs_q       <= '0;
      ex_rt_q       <= '0;
      ex_reg3_q     <= '0;
      ex_regWrite_q <= 1'b0;
      ex_memRead_q  <= 1'b0;
      ex_memWrite_q <= 1'b0;
      ex_aluSrc_q   <= 1'b0;
      ex_aluOp_q    <= ALUOP_W'(ALU_NOP);
      ex_rdata1_q   <= '0;
      ex_rdata2_q   <= '0;
      ex_imm_q      <= '0;
    end else if (hold_i) begin
      if (flush_i) pend_flush_q <= 1'b1;
    end else if (flush_i || pend_flush_q || lu_hit) begin
      // Bubble: flush kills ID; load-use leaves ID parked upstream via stall_o.
      state_q       <= (flush_i || pend_flush_q) ? ST_RUN : ST_BUBBLE;
      pend_flush_q  <= 1'b0;
      ex_valid_q    <= 1'b0;
      ex_rs_q       <= '0;
      ex_rt_q       <= '0;
      ex_reg3_q     <= '0;
      ex_regWrite_q <= 1'b0;
      ex_memRead_q  <= 1'b0;
      ex_memWrite_q <= 1'b0;
      ex_aluSrc_q   <= 1'b0;
      ex_aluOp_q    <= ALUOP_W'(ALU_NOP);
      ex_rdata1_q   <= '0;
      ex_rdata2_q   <= '0;
      ex_imm_q      <= '0;
    end else begin
      state_q       <= ST_RUN;
      ex_valid_q    <= id_valid_i;
      ex_rs_q       <= id_rs_i;
      ex_rt_q       <= id_rt_i;
      ex_reg3_q     <= id_reg3_i;
      ex_regWrite_q <= id_regWrite_i;
      ex_memRead_q  <= id_memRead_i;
      ex_memWrite_q <= id_memWrite_i;
      ex_aluSrc_q   <= id_aluSrc_i;
      ex_aluOp_q    <= id_aluOp_i;
      ex_rdata1_q   <= id_rdata1_i;
      ex_rdata2_q   <= id_rdata2_i;
      ex_imm_q      <= id_imm_i;
    end
  end

`ifdef LOAD_USE_STAT_EN
  logic        enter_bubble;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign enter_bubble = (state_q == ST_RUN) & lu_hit & ~hold_i & ~flush_i & ~pend_flush_q;
  assign stall_cnt_d  = stall_cnt_q + 32'd1;   // wraps naturally at 2^32

  // Count each RUN -> BUBBLE transition, i.e. each load-use stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            stall_cnt_q <= '0;
    else if (enter_bubble) stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

  assign ex_valid_o    = ex_valid_q;
  assign ex_rs_o       = ex_rs_q;
  assign ex_rt_o       = ex_rt_q;
  assign ex_reg3_o     = ex_reg3_q;
  assign ex_regWrite_o = ex_regWrite_q;
  assign ex_memRead_o  = ex_memRead_q;
  assign ex_memWrite_o = ex_memWrite_q;
  assign ex_aluSrc_o   = ex_aluSrc_q;
  assign ex_aluOp_o    = ex_aluOp_q;
  assign ex_rdata1_o   = ex_rdata1_q;
  assign ex_rdata2_o   = ex_rdata2_q;
  assign ex_imm_o      = ex_imm_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg: reset, pass-through,
// load-use on rs/rt, $0 destination, flush priority, hold with pending flush,
// stall counter and reset in the middle of a stall.
module tb_id_ex_stage_reg;
  import id_ex_stage_reg_pkg::*;

`ifdef LOAD_USE_STAT_EN
  localparam int STAT = 1;
`else
  localparam int STAT = 0;
`endif

  logic        clk, rst_n;
  logic        id_valid_i, id_rtUsed_i, id_regWrite_i, id_memRead_i, id_memWrite_i, id_aluSrc_i;
  logic [4:0]  id_rs_i, id_rt_i, id_reg3_i;
  logic [3:0]  id_aluOp_i;
  logic [31:0] id_rdata1_i, id_rdata2_i, id_imm_i;
  logic        flush_i, hold_i, stall_o;
  logic        ex_valid_o, ex_regWrite_o, ex_memRead_o, ex_memWrite_o, ex_aluSrc_o;
  logic [4:0]  ex_rs_o, ex_rt_o, ex_reg3_o;
  logic [3:0]  ex_aluOp_o;
  logic [31:0] ex_rdata1_o, ex_rdata2_o, ex_imm_o, stall_cnt_o;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  id_ex_stage_reg #(.DATA_W(32), .ALUOP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rtUsed_i(id_rtUsed_i),
    .id_reg3_i(id_reg3_i), .id_regWrite_i(id_regWrite_i), .id_memRead_i(id_memRead_i),
    .id_memWrite_i(id_memWrite_i), .id_aluSrc_i(id_aluSrc_i), .id_aluOp_i(id_aluOp_i),
    .id_rdata1_i(id_rdata1_i), .id_rdata2_i(id_rdata2_i), .id_imm_i(id_imm_i),
    .flush_i(flush_i), .hold_i(hold_i), .stall_o(stall_o),
    .ex_valid_o(ex_valid_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_reg3_o(ex_reg3_o),
    .ex_regWrite_o(ex_regWrite_o), .ex_memRead_o(ex_memRead_o), .ex_memWrite_o(ex_memWrite_o),
    .ex_aluSrc_o(ex_aluSrc_o), .ex_aluOp_o(ex_aluOp_o), .ex_rdata1_o(ex_rdata1_o),
    .ex_rdata2_o(ex_rdata2_o), .ex_imm_o(ex_imm_o), .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a valid instruction in ID; operand data derived from the regs.
  task automatic id_instr(input logic [4:0] rs, input logic [4:0] rt, input logic rt_used,
                          input logic [4:0] reg3, input logic mem_read,
                          input logic [3:0] aluop, input logic [31:0] imm);
    id_valid_i    = 1'b1;
    id_rs_i       = rs;
    id_rt_i       = rt;
    id_rtUsed_i   = rt_used;
    id_reg3_i     = reg3;
    id_regWrite_i = 1'b1;
    id_memRead_i  = mem_read;
    id_memWrite_i = 1'b0;
    id_aluSrc_i   = mem_read;
    id_aluOp_i    = aluop;
    id_rdata1_i   = 32'h1000 + 32'(rs);
    id_rdata2_i   = 32'h2000 + 32'(rt);
    id_imm_i      = imm;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
    id_instr(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 4'h2, 32'h0);

    // Reset: everything a bubble even with a live ID instruction.
    repeat (2) tick();
    check("rst_valid",  32'(ex_valid_o), 0);
    check("rst_reg3",   32'(ex_reg3_o), 0);
    check("rst_regw",   32'(ex_regWrite_o), 0);
    check("rst_memw",   32'(ex_memWrite_o), 0);
    check("rst_rdata1", ex_rdata1_o, 0);
    check("rst_state",  32'(dut.state_q), 32'(ST_RUN));
    check("rst_cnt",    stall_cnt_o, 0);

    // Pass-through: add $3 = $1 + $2.
    rst_n = 1'b1;
    #1 check("pass_stall0", 32'(stall_o), 0);
    tick();
    check("pass_reg3",   32'(ex_reg3_o), 3);
    check("pass_valid",  32'(ex_valid_o), 1);
    check("pass_rs",     32'(ex_rs_o), 1);
    check("pass_aluop",  32'(ex_aluOp_o), 2);
    check("pass_rdata2", ex_rdata2_o, 32'h2002);
    check("pass_stall1", 32'(stall_o), 0);

    // Load-use on rs: lw $5 then add $7 = $5 + $6.
    id_instr(5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 4'h0, 32'h4);
    tick();
    check("lw_memread", 32'(ex_memRead_o), 1);
    check("lw_imm",     ex_imm_o, 32'h4);
    id_instr(5'd5, 5'd6, 1'b1, 5'd7, 1'b0, 4'h2, 32'h0);
    #1 check("lu_rs_stall", 32'(stall_o), 1);
    tick();
    check("lu_rs_bub_valid", 32'(ex_valid_o), 0);
    check("lu_rs_bub_regw",  32'(ex_regWrite_o), 0);
    check("lu_rs_state",     32'(dut.state_q), 32'(ST_BUBBLE));
    check("lu_rs_stall_off", 32'(stall_o), 0);
    tick();
    exp_cnt += STAT;
    check("lu_rs_add_rs",    32'(ex_rs_o), 5);
    check("lu_rs_add_reg3",  32'(ex_reg3_o), 7);
    check("lu_rs_add_valid", 32'(ex_valid_o), 1);
    check("lu_rs_run",       32'(dut.state_q), 32'(ST_RUN));
    check("lu_rs_cnt",       stall_cnt_o, 32'(exp_cnt));

    // rt match: no stall while rtUsed=0, stall once rtUsed=1.
    id_instr(5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 4'h0, 32'h8);
    tick();
    id_instr(5'd1, 5'd5, 1'b0, 5'd8, 1'b0, 4'h1, 32'h10);
    #1 check("lu_rt_unused", 32'(stall_o), 0);
    id_rtUsed_i = 1'b1;
    #1 check("lu_rt_used", 32'(stall_o), 1);
    id_rtUsed_i = 1'b0;
    #1 tick();
    check("lu_rt_nobub_valid", 32'(ex_valid_o), 1);
    check("lu_rt_nobub_rt",    32'(ex_rt_o), 5);
    check("lu_rt_nobub_reg3",  32'(ex_reg3_o), 8);

    // Load into $0 never stalls.
    id_instr(5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 4'h0, 32'h0);
    tick();
    id_instr(5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 4'h2, 32'h0);
    #1 check("lu_r0_stall", 32'(stall_o), 0);
    tick();
    check("lu_r0_reg3", 32'(ex_reg3_o), 9);

    // Flush beats load-use.
    id_instr(5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 4'h0, 32'h0);
    tick();
    id_instr(5'd5, 5'd0, 1'b0, 5'd10, 1'b0, 4'h2, 32'h0);
    flush_i = 1'b1;
    #1 check("fl_stall", 32'(stall_o), 0);
    tick();
    flush_i = 1'b0;
    check("fl_bub_valid", 32'(ex_valid_o), 0);
    check("fl_state",     32'(dut.state_q), 32'(ST_RUN));
    check("fl_cnt",       stall_cnt_o, 32'(exp_cnt));
    tick();
    check("fl_next_reg3", 32'(ex_reg3_o), 10);

    // Hold for 3 cycles with a flush pulse in cycle 2.
    id_instr(5'd1, 5'd0, 1'b0, 5'd11, 1'b0, 4'h2, 32'h0);
    hold_i = 1'b1;
    #1 check("hold_stall", 32'(stall_o), 1);
    tick();
    check("hold_c1_reg3", 32'(ex_reg3_o), 10);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("hold_c2_reg3", 32'(ex_reg3_o), 10);
    tick();
    check("hold_c3_reg3",  32'(ex_reg3_o), 10);
    check("hold_c3_valid", 32'(ex_valid_o), 1);
    check("hold_c3_stall", 32'(stall_o), 1);
    hold_i = 1'b0;
    #1 check("hold_rel_stall", 32'(stall_o), 0);
    tick();
    check("hold_pend_bub", 32'(ex_valid_o), 0);
    check("hold_pend_clr", 32'(dut.pend_flush_q), 0);
    tick();
    check("hold_after_reg3", 32'(ex_reg3_o), 11);

    // Load-use interrupted by a 2-cycle hold: still exactly one bubble.
    id_instr(5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 4'h0, 32'h0);
    tick();
    id_instr(5'd5, 5'd0, 1'b0, 5'd12, 1'b0, 4'h2, 32'h0);
    hold_i = 1'b1;
    repeat (2) tick();
    check("luh_frozen_lw", 32'(ex_memRead_o), 1);
    check("luh_state_run", 32'(dut.state_q), 32'(ST_RUN));
    hold_i = 1'b0;
    #1 check("luh_stall", 32'(stall_o), 1);
    tick();
    check("luh_bubble", 32'(dut.state_q), 32'(ST_BUBBLE));
    tick();
    exp_cnt += STAT;
    check("luh_reg3", 32'(ex_reg3_o), 12);

    // Two more load-use events on rt.
    for (int k = 0; k < 2; k++) begin
      id_instr(5'd1, 5'd0, 1'b0, 5'(20 + k), 1'b1, 4'h0, 32'h0);
      tick();
      id_instr(5'd1, 5'(20 + k), 1'b1, 5'd25, 1'b0, 4'h2, 32'h0);
      #1 check("lul_stall", 32'(stall_o), 1);
      tick();
      check("lul_bub", 32'(ex_valid_o), 0);
      tick();
      exp_cnt += STAT;
      check("lul_reg3", 32'(ex_reg3_o), 25);
    end
    check("cnt_total", stall_cnt_o, 32'(exp_cnt));

    // Reset while stalling: stall drops immediately, EX becomes a bubble.
    id_instr(5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 4'h0, 32'h0);
    tick();
    id_instr(5'd5, 5'd0, 1'b0, 5'd13, 1'b0, 4'h2, 32'h0);
    #1 check("rstm_stall_before", 32'(stall_o), 1);
    rst_n = 1'b0;
    #1;
    check("rstm_stall", 32'(stall_o), 0);
    check("rstm_valid", 32'(ex_valid_o), 0);
    check("rstm_state", 32'(dut.state_q), 32'(ST_RUN));
    check("rstm_cnt",   stall_cnt_o, 0);
    tick();
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
